mem_stage: RTL and testbench

- Memory stage of the 5-stage core. Consumes the ex_mem_t bundle produced by the execute stage and performs loads and stores over a request/grant/response data-memory bus.
- Sizes and aligns store data and load data per funct3.
- Stalls the pipeline while an access is outstanding.
- Owns the MEM/WB pipeline register and drives a registered mem_wb_t bundle to writeback.

---
 rtl/mem_stage.sv | 208 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory stage with a req/gnt/rvalid data bus and the MEM/WB register.
// Revision : 1.0  initial release
// ============================================================================

package mem_stage_pkg;
    typedef struct packed {
        logic [31:0] aluresult;
        logic [31:0] writedata;
        logic [31:0] pcplus4;
        logic [4:0]  rd;
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic        memwrite;
        logic [2:0]  funct3;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] aluresult;
        logic [31:0] readdata;
        logic [31:0] pcplus4;
        logic [4:0]  rd;
        logic        regwrite;
        logic [1:0]  resultsrc;
    } mem_wb_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [1:0] RESULTSRC_MEM  = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  ex_mem_t     in,
    output mem_wb_t     out,
    output logic        stall_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        misalign,
    output logic        bus_err
);
    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_cnt_w-1:0] r_cnt;

    logic        w_store, w_load, w_half, w_word, w_misaligned, w_timeout;
    logic        w_req, w_stall, w_mis, w_berr, w_load_done;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_ld_data;
    logic [1:0]  w_a;

    assign w_a          = in.aluresult[1:0];
    assign w_store      = in.memwrite;
    assign w_load       = (in.resultsrc == RESULTSRC_MEM) && !in.memwrite;
    assign w_half       = (in.funct3[1:0] == 2'b01);
    assign w_word       = in.funct3[1];
    assign w_misaligned = (w_half && w_a[0]) || (w_word && (w_a != 2'b00));
    assign w_timeout    = (r_cnt == c_cnt_last);

    always_comb begin
        w_next      = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_mis       = 1'b0;
        w_berr      = 1'b0;
        w_load_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((w_store || w_load) && w_misaligned) begin
                    w_mis = 1'b1;
                end else if (w_store || w_load) begin
                    w_req = 1'b1;
                    if (!dmem_gnt) begin
                        w_next  = S_REQ;
                        w_stall = 1'b1;
                    end else if (w_load) begin
                        w_next  = S_WAIT;
                        w_stall = 1'b1;
                    end
                end
            end
            S_REQ: begin
                w_req = 1'b1;
                if (dmem_gnt) begin
                    if (w_store) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next  = S_WAIT;
                        w_stall = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_berr = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid) begin
                    w_load_done = 1'b1;
                    w_next      = S_IDLE;
                end else if (w_timeout) begin
                    w_berr = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Nothing may be requested or stalled while reset is held.
        if (reset) begin
            w_req   = 1'b0;
            w_stall = 1'b0;
            w_mis   = 1'b0;
            w_berr  = 1'b0;
        end
    end

    always_comb begin
        w_lane_b = dmem_rdata[7:0];
        case (w_a)
            2'd1:    w_lane_b = dmem_rdata[15:8];
            2'd2:    w_lane_b = dmem_rdata[23:16];
            2'd3:    w_lane_b = dmem_rdata[31:24];
            default: w_lane_b = dmem_rdata[7:0];
        endcase
        w_lane_h = w_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (in.funct3[1:0])
            2'b00:   w_ld_data = {{24{!in.funct3[2] && w_lane_b[7]}}, w_lane_b};
            2'b01:   w_ld_data = {{16{!in.funct3[2] && w_lane_h[15]}}, w_lane_h};
            default: w_ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        case (in.funct3[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << w_a;
                dmem_wdata = {4{in.writedata[7:0]}};
            end
            2'b01: begin
                dmem_be    = w_a[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{in.writedata[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = in.writedata;
            end
        endcase
    end

    assign dmem_req  = w_req;
    assign dmem_we   = w_store;
    assign dmem_addr = {in.aluresult[31:2], 2'b00};
    assign stall_m   = w_stall;
    assign misalign  = w_mis;
    assign bus_err   = w_berr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            out     <= '0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) && (w_next != S_IDLE)) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
            // A stalled instruction is captured only once, on its final cycle.
            if (w_stall) begin
                out <= '0;
            end else begin
                out.aluresult <= in.aluresult;
                out.readdata  <= w_load_done ? w_ld_data : 32'd0;
                out.pcplus4   <= in.pcplus4;
                out.rd        <= in.rd;
                out.regwrite  <= in.regwrite && !w_mis && !w_berr;
                out.resultsrc <= in.resultsrc;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Randomized transaction-level checking of mem_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset;
    ex_mem_t     in;
    mem_wb_t     out;
    logic        stall_m, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        misalign, bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    mem_stage #(.TIMEOUT_CYCLES(T), .RESULTSRC_MEM(2'b01)) dut (
        .clk(clk), .reset(reset), .in(in), .out(out), .stall_m(stall_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] ref_be(input int sz, input int a);
        if (sz == 0) return 4'(1 << a);
        if (sz == 1) return 4'(3 << (a & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] wd);
        if (sz == 0) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a, input logic [31:0] d);
        logic [31:0] v;
        if (f3[1:0] == 2'b00) begin
            v = (d >> (8 * a)) & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v - 32'd256;
        end else if (f3[1:0] == 2'b01) begin
            v = (d >> (8 * (a & 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // g: cycles of gnt low before gnt; r: cycles from gnt to rvalid (loads).
    // Must be entered right after a negative clock edge.
    task automatic run_txn(input ex_mem_t t, input int g, input int r, input logic [31:0] rdat);
        logic    st, ld, mis, err;
        int      sz, a, e;
        mem_wb_t exp;
        st  = t.memwrite;
        ld  = (t.resultsrc == 2'b01) && !t.memwrite;
        sz  = int'(t.funct3[1:0]);
        a   = int'(t.aluresult[1:0]);
        mis = (st || ld) && ((sz == 1 && (a % 2) == 1) || (sz >= 2 && a != 0));
        if (!(st || ld) || mis) begin e = 0;     err = 1'b0; end
        else if (g > T)         begin e = T;     err = 1'b1; end
        else if (st)            begin e = g;     err = 1'b0; end
        else if (r > T)         begin e = g + T; err = 1'b1; end
        else                    begin e = g + r; err = 1'b0; end
        in = t;
        for (int k = 0; k <= e; k++) begin
            dmem_gnt    = (st || ld) && !mis && (k == g);
            dmem_rvalid = ld && !mis && (g <= T) && (k == g + r);
            dmem_rdata  = dmem_rvalid ? rdat : $urandom;
            #1;
            check("stall_m", stall_m, k < e);
            check("dmem_req", dmem_req, (st || ld) && !mis && k <= g && k <= T);
            if ((st || ld) && !mis && k <= g && k <= T)
                check("req_payload", {dmem_we, dmem_be, dmem_addr, dmem_wdata},
                      {st, ref_be(sz, a), t.aluresult & 32'hFFFFFFFC, ref_wdata(sz, t.writedata)});
            check("misalign", misalign, mis && k == 0);
            check("bus_err", bus_err, err && k == e);
            if (k > 0) check("bubble", out, 104'd0);
            @(negedge clk);
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        exp.aluresult = t.aluresult;
        exp.readdata  = (ld && !mis && !err) ? ref_load(t.funct3, a, rdat) : 32'd0;
        exp.pcplus4   = t.pcplus4;
        exp.rd        = t.rd;
        exp.regwrite  = t.regwrite && !mis && !err;
        exp.resultsrc = t.resultsrc;
        check("out", out, exp);
    endtask

    function automatic ex_mem_t mk(input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [1:0] rs, input logic mw, input logic [2:0] f3);
        ex_mem_t t;
        t.aluresult = addr;
        t.writedata = wd;
        t.pcplus4   = 32'h0000_0104;
        t.rd        = 5'd7;
        t.regwrite  = !mw;
        t.resultsrc = rs;
        t.memwrite  = mw;
        t.funct3    = f3;
        return t;
    endfunction

    initial begin
        ex_mem_t t;
        int      kind, g, r;
        logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        reset       = 1'b1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        in          = mk(32'h100, 32'h0, 2'b01, 1'b0, 3'd2);
        @(negedge clk);
        #1;
        check("rst_req", dmem_req, 1'b0);
        check("rst_stall", stall_m, 1'b0);
        @(negedge clk);
        check("rst_out", out, 104'd0);
        reset = 1'b0;

        // Directed cases
        t = mk(32'h10, 32'h0, 2'b00, 1'b0, 3'd0);
        t.rd = 5'd5;
        run_txn(t, 0, 0, 32'h0);
        check("alu_out", {out.aluresult, out.rd, out.regwrite}, {32'h10, 5'd5, 1'b1});
        run_txn(mk(32'h1003, 32'hA5, 2'b00, 1'b1, 3'd0), 0, 0, 32'h0);
        run_txn(mk(32'h2002, 32'h0, 2'b01, 1'b0, 3'd1), 0, 2, 32'h8001_7FFF);
        check("lh_readdata", out.readdata, 32'hFFFF8001);
        run_txn(mk(32'h3001, 32'h0, 2'b01, 1'b0, 3'd4), 3, 1, 32'h0000_F000);
        check("lbu_readdata", out.readdata, 32'h000000F0);
        run_txn(mk(32'h4002, 32'h0, 2'b01, 1'b0, 3'd2), 0, 1, 32'h0);
        run_txn(mk(32'h4000, 32'h0, 2'b01, 1'b0, 3'd2), 0, 99, 32'h0);
        run_txn(mk(32'h4800, 32'h1234, 2'b00, 1'b1, 3'd2), 99, 0, 32'h0);

        // Reset while waiting for load data
        in       = mk(32'h5000, 32'h0, 2'b01, 1'b0, 3'd2);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        reset    = 1'b1;
        #1;
        check("rstw_stall", stall_m, 1'b0);
        check("rstw_req", dmem_req, 1'b0);
        @(negedge clk);
        reset       = 1'b0;
        in          = '0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEADBEEF;
        #1;
        check("rstw_stall2", stall_m, 1'b0);
        check("rstw_out", out, 104'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        check("rstw_out2", out, 104'd0);
        check("rstw_buserr", bus_err, 1'b0);
        @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 2));
            t.aluresult = $urandom;
            t.writedata = $urandom;
            t.pcplus4   = $urandom;
            t.rd        = 5'($urandom);
            t.regwrite  = 1'($urandom);
            if (kind == 0) begin
                t.resultsrc = $urandom_range(0, 1) ? 2'b10 : 2'b00;
                t.memwrite  = 1'b0;
                t.funct3    = 3'($urandom);
            end else if (kind == 1) begin
                t.resultsrc = 2'b00;
                t.memwrite  = 1'b1;
                t.funct3    = 3'($urandom_range(0, 2));
            end else begin
                t.resultsrc = 2'b01;
                t.memwrite  = 1'b0;
                t.funct3    = ld_f3[$urandom_range(0, 4)];
            end
            g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T + 1, T + 3)) : int'($urandom_range(0, 3));
            r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T + 1, T + 3)) : int'($urandom_range(1, 3));
            run_txn(t, g, r, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
